ibex_multdiv_arbiter: RTL and testbench
=======================================

IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 Parameter RoundRobin, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid_i  input  1  requester N (N = 0,1) presents an operation.
REQ-005 reqN_ready_o  output  1  operation of requester N accepted this cycle.
REQ-006 reqN_operator_i  input  2  ibex_pkg::md_op_e: MULL, MULH, DIV or REM.
REQ-007 reqN_signed_mode_i  input  2  bit0 = operand A signed; bit1 = operand B signed.
REQ-008 reqN_op_a_i, reqN_op_b_i  input  32 each  operands.
REQ-009 reqN_rvalid_o  output  1  one-cycle result strobe to requester N.
REQ-010 reqN_result_o  output  32  result; meaningful only while reqN_rvalid_o = 1.
REQ-011 abort_i  input  1  cancel the current operation (pipeline flush).
REQ-012 md_mult_en_o, md_div_en_o  output  1 each  enables to the shared multiplier/divider.
REQ-013 md_operator_o  output  2  md_op_e. md_signed_mode_o  output  2.
REQ-014 md_op_a_o, md_op_b_o  output  32 each  operands to the unit.
REQ-015 md_result_i  input  32. md_valid_i  input  1  unit-done strobe.
REQ-016 busy_o  output  1  state is not IDLE.

Function
REQ-017 FSM states: IDLE, BUSY, RESP, DRAIN.
REQ-018 IDLE: if abort_i = 0 and any reqN_valid_i = 1, assert reqN_ready_o for exactly one winner (combinational, same cycle); latch its operator, signed mode, operands and owner index; go to BUSY.
REQ-019 With RoundRobin = 1, both requesting: grant the requester not granted most recently; otherwise grant the only requester.
REQ-020 With RoundRobin = 0, requester 0 always wins a tie.
REQ-021 BUSY: drive the latched values on md_* outputs, held constant for the whole operation; assert md_mult_en_o for MULL/MULH, or md_div_en_o for DIV/REM, never both.
REQ-022 BUSY, md_valid_i = 1: latch md_result_i and go to RESP; keep the enable asserted in that cycle and deassert it from the next cycle.
REQ-023 RESP: assert reqN_rvalid_o for the owner only, for exactly one cycle, with the latched result; no backpressure; go to IDLE.
REQ-024 The first new grant is in the cycle after RESP, giving a minimum accept-to-accept spacing of unit latency + 2 cycles.
REQ-025 abort_i in BUSY: go to DRAIN that cycle; the md_valid_i of the same cycle is discarded.
REQ-026 DRAIN: keep the enable and operands asserted until md_valid_i; discard the result; no rvalid; go to IDLE. This returns the unit's internal FSM to its idle state.
REQ-027 abort_i in RESP: suppress rvalid; go to IDLE.
REQ-028 abort_i in IDLE: no grant that cycle.
REQ-029 abort_i in DRAIN: no effect.
REQ-030 reqN_ready_o = 0 in every state except IDLE; a requester holds its valid and operands until ready.
REQ-031 Result width is 32 bits, passed unmodified; the arbiter performs no arithmetic.
REQ-032 md_* enables are 0 in IDLE and RESP. When enables are low, md_op_a_o, md_op_b_o, md_operator_o and md_signed_mode_o hold their last values.

Reset
REQ-033 rst_ni low, asynchronously at any time including mid-operation: state IDLE; all ready, rvalid, enable and busy outputs 0; latched operands, result and md_* data outputs 0; last-grant register = 1, so requester 0 wins the first tie.
REQ-034 The shared unit is reset by the same rst_ni; no drain is required after reset.

Verification
REQ-035 req0 MULL, A = 7, B = 6, unsigned -> req0_ready_o in the accept cycle, md_mult_en_o from the next cycle, req0_rvalid_o one cycle after md_valid_i, result = 42.
REQ-036 req0 and req1 both valid in IDLE after reset, DIV 100/7 and REM 100/7 -> req0 granted first with result 14, then req1 with result 2; reverse priority at the next tie.
REQ-037 req1 DIV, A = 100, B = 0 -> result 0xFFFF_FFFF; REM 100/0 -> result 100.
REQ-038 abort_i pulsed during a DIV in BUSY -> DRAIN, md_div_en_o held until md_valid_i, no rvalid; a following MULH 0xFFFF_FFFF * 0xFFFF_FFFF signed = 0x0000_0000 completes correctly.
REQ-039 rst_ni asserted mid-MULH -> all outputs 0 immediately; after release, MULL 3*5 returns 15.
REQ-040 RoundRobin = 0, both requesting continuously -> req0 granted every time; req1 granted only when req0_valid_i = 0.

Source files
------------

// File: rtl/ibex_multdiv_arbiter.sv
// ibex_multdiv_arbiter
// Shares one multiplier/divider unit between two requesters. A request is
// accepted in IDLE, its operator/operands are latched and driven to the unit
// while BUSY, and the unit's result is returned to the owning requester as a
// one-cycle strobe in RESP. An abort during BUSY moves to DRAIN, which keeps
// the unit enabled until it reports done so that the unit ends up idle, and
// then discards the result.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o   request handshake of requester N (0, 1)
//   reqN_operator_i               MULL=0, MULH=1, DIV=2, REM=3
//   reqN_signed_mode_i            bit0: op A signed, bit1: op B signed
//   reqN_op_a_i, reqN_op_b_i      32-bit operands
//   reqN_rvalid_o, reqN_result_o  one-cycle result strobe and result
//   abort_i                       pipeline flush
//   md_*_o                        enables, operator, mode, operands to the unit
//   md_result_i, md_valid_i       unit result and done strobe
//   busy_o                        arbiter not in IDLE
module ibex_multdiv_arbiter #(
  parameter bit RoundRobin = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_operator_i,
  input  logic [1:0]  req0_signed_mode_i,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  output logic        req0_rvalid_o,
  output logic [31:0] req0_result_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_operator_i,
  input  logic [1:0]  req1_signed_mode_i,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  output logic        req1_rvalid_o,
  output logic [31:0] req1_result_o,
  input  logic        abort_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic [31:0] md_result_i,
  input  logic        md_valid_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  operator_q, operator_d;
  logic [1:0]  signed_mode_q, signed_mode_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;

  logic        winner_s;
  logic        grant_s;
  logic        unit_en_s;
  logic        resp_s;

  // Pick the winner among the current requesters.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      if (RoundRobin) begin
        winner_s = ~last_grant_q;
      end else begin
        winner_s = 1'b0;
      end
    end else if (req1_valid_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Gating with rst_ni keeps ready low while reset is asserted, even though
  // the state register already reads IDLE.
  assign grant_s = rst_ni && (state_q == IDLE) && !abort_i &&
                   (req0_valid_i || req1_valid_i);

  // Next-state and latch updates.
  always_comb begin
    state_d       = state_q;
    operator_d    = operator_q;
    signed_mode_d = signed_mode_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    result_d      = result_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d       = BUSY;
          owner_d       = winner_s;
          last_grant_d  = winner_s;
          operator_d    = winner_s ? req1_operator_i    : req0_operator_i;
          signed_mode_d = winner_s ? req1_signed_mode_i : req0_signed_mode_i;
          op_a_d        = winner_s ? req1_op_a_i        : req0_op_a_i;
          op_b_d        = winner_s ? req1_op_b_i        : req0_op_b_i;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Abort takes precedence: a done strobe in the same cycle is dropped.
        if (abort_i) begin
          state_d = DRAIN;
        end else if (md_valid_i) begin
          result_d = md_result_i;
          state_d  = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (md_valid_i) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request/result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      operator_q    <= 2'd0;
      signed_mode_q <= 2'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      result_q      <= 32'd0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      result_q      <= result_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // The unit stays enabled through DRAIN so that it runs to completion.
  assign unit_en_s = (state_q == BUSY) || (state_q == DRAIN);
  // operator bit1 distinguishes DIV/REM from MULL/MULH.
  assign md_mult_en_o     = unit_en_s && !operator_q[1];
  assign md_div_en_o      = unit_en_s && operator_q[1];
  assign md_operator_o    = operator_q;
  assign md_signed_mode_o = signed_mode_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;

  assign resp_s        = (state_q == RESP) && !abort_i;
  assign req0_rvalid_o = resp_s && !owner_q;
  assign req1_rvalid_o = resp_s && owner_q;
  assign req0_result_o = result_q;
  assign req1_result_o = result_q;

  assign req0_ready_o = grant_s && !winner_s;
  assign req1_ready_o = grant_s && winner_s;

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Testbench for ibex_multdiv_arbiter. Two instances share the requester
// inputs: u_rr (round-robin) is the main subject, u_fp (fixed priority) is
// used for the priority scenario. A behavioural multiplier/divider model with
// a programmable latency answers each instance's unit interface.
module tb_ibex_multdiv_arbiter;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        abort;
  logic [1:0]  vld;
  logic [1:0]  opr [2];
  logic [1:0]  sgn [2];
  logic [31:0] opa [2];
  logic [31:0] opb [2];

  logic [1:0]  rdy_s, rv_s, f_rdy_s, f_rv_s;
  logic [31:0] res_s [2];
  logic [31:0] f_res_s [2];

  // Unit-side signals, index 0 = u_rr, index 1 = u_fp.
  logic [1:0]  mult_en, div_en, busy, md_valid;
  logic [1:0]  md_opr [2];
  logic [1:0]  md_sgn [2];
  logic [31:0] md_a [2];
  logic [31:0] md_b [2];
  logic [31:0] md_res [2];

  int lat;
  int cnt [2];
  int n_pass, n_total;

  always #5 clk = ~clk;

  ibex_multdiv_arbiter #(.RoundRobin(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(vld[0]), .req0_ready_o(rdy_s[0]), .req0_operator_i(opr[0]),
    .req0_signed_mode_i(sgn[0]), .req0_op_a_i(opa[0]), .req0_op_b_i(opb[0]),
    .req0_rvalid_o(rv_s[0]), .req0_result_o(res_s[0]),
    .req1_valid_i(vld[1]), .req1_ready_o(rdy_s[1]), .req1_operator_i(opr[1]),
    .req1_signed_mode_i(sgn[1]), .req1_op_a_i(opa[1]), .req1_op_b_i(opb[1]),
    .req1_rvalid_o(rv_s[1]), .req1_result_o(res_s[1]),
    .abort_i(abort), .md_mult_en_o(mult_en[0]), .md_div_en_o(div_en[0]),
    .md_operator_o(md_opr[0]), .md_signed_mode_o(md_sgn[0]),
    .md_op_a_o(md_a[0]), .md_op_b_o(md_b[0]),
    .md_result_i(md_res[0]), .md_valid_i(md_valid[0]), .busy_o(busy[0])
  );

  ibex_multdiv_arbiter #(.RoundRobin(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(vld[0]), .req0_ready_o(f_rdy_s[0]), .req0_operator_i(opr[0]),
    .req0_signed_mode_i(sgn[0]), .req0_op_a_i(opa[0]), .req0_op_b_i(opb[0]),
    .req0_rvalid_o(f_rv_s[0]), .req0_result_o(f_res_s[0]),
    .req1_valid_i(vld[1]), .req1_ready_o(f_rdy_s[1]), .req1_operator_i(opr[1]),
    .req1_signed_mode_i(sgn[1]), .req1_op_a_i(opa[1]), .req1_op_b_i(opb[1]),
    .req1_rvalid_o(f_rv_s[1]), .req1_result_o(f_res_s[1]),
    .abort_i(abort), .md_mult_en_o(mult_en[1]), .md_div_en_o(div_en[1]),
    .md_operator_o(md_opr[1]), .md_signed_mode_o(md_sgn[1]),
    .md_op_a_o(md_a[1]), .md_op_b_o(md_b[1]),
    .md_result_i(md_res[1]), .md_valid_i(md_valid[1]), .busy_o(busy[1])
  );

  // RISC-V M-extension semantics on 33-bit extended operands.
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sm,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    case (op)
      OP_MULL: return p[31:0];
      OP_MULH: return p[63:32];
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
    endcase
  endfunction

  // Unit model: after 'lat' enabled cycles, strobe done with the result.
  initial begin
    cnt[0] = 0; cnt[1] = 0; md_valid = 2'b00;
    md_res[0] = 32'd0; md_res[1] = 32'd0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_ni) begin
          cnt[i] = 0; md_valid[i] = 1'b0;
        end else if (md_valid[i]) begin
          cnt[i] = 0; md_valid[i] = 1'b0;
        end else if (mult_en[i] || div_en[i]) begin
          cnt[i]++;
          if (cnt[i] >= lat) begin
            md_valid[i] = 1'b1;
            md_res[i] = ref_md(md_opr[i], md_sgn[i], md_a[i], md_b[i]);
          end
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic present(input int n, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b);
    vld[n] = 1'b1; opr[n] = op; sgn[n] = sm; opa[n] = a; opb[n] = b;
  endtask

  // Returns the ready vector of the first granting cycle (0 on timeout).
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int k = 0; k < 50; k++) begin
      #1; g = rdy_s;
      @(posedge clk); #1;
      if (g != 2'b00) break;
    end
  endtask

  // Returns the rvalid vector, result and cycles since the last done strobe.
  task automatic wait_result(output logic [1:0] w, output logic [31:0] r, output int gap);
    int mdv;
    w = 2'b00; r = 32'd0; gap = -1; mdv = -100;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (rv_s != 2'b00) begin
        w = rv_s; r = rv_s[1] ? res_s[1] : res_s[0]; gap = k - mdv;
      end else if (md_valid[0]) begin
        mdv = k;
      end
      @(posedge clk); #1;
      if (w != 2'b00) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0; vld = 2'b00; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    present(0, OP_MULL, 2'b00, 32'd1, 32'd1);
    present(1, OP_DIV, 2'b00, 32'd1, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    n_total++; if (rdy_s !== 2'b00) $display("FAIL reset_ready: got %b want 00", rdy_s); else n_pass++;
    n_total++; if (busy !== 2'b00) $display("FAIL reset_busy: got %b want 00", busy); else n_pass++;
    n_total++; if ({mult_en, div_en} !== 4'b0000) $display("FAIL reset_en: got %b want 0000", {mult_en, div_en}); else n_pass++;
    n_total++; if ({md_a[0], md_b[0], md_opr[0], md_sgn[0]} !== 68'd0) $display("FAIL reset_md_data: got %h want 0", {md_a[0], md_b[0], md_opr[0], md_sgn[0]}); else n_pass++;
    n_total++; if ({rv_s, res_s[0]} !== 34'd0) $display("FAIL reset_rvalid_result: got %h want 0", {rv_s, res_s[0]}); else n_pass++;
    vld = 2'b00;
    @(posedge clk); #1; rst_ni = 1'b1;
  endtask

  task automatic test_mull();
    logic [1:0] w; logic [31:0] r; int gap;
    do_reset(); lat = 2;
    present(0, OP_MULL, 2'b00, 32'd7, 32'd6);
    #1;
    n_total++; if (rdy_s !== 2'b01) $display("FAIL mull_accept_ready: got %b want 01", rdy_s); else n_pass++;
    n_total++; if (mult_en[0] !== 1'b0) $display("FAIL mull_en_in_accept: got %b want 0", mult_en[0]); else n_pass++;
    @(posedge clk); #1; vld[0] = 1'b0; #1;
    n_total++; if ({busy[0], mult_en[0], div_en[0]} !== 3'b110) $display("FAIL mull_busy_en: got %b want 110", {busy[0], mult_en[0], div_en[0]}); else n_pass++;
    n_total++; if ({md_a[0], md_b[0]} !== {32'd7, 32'd6}) $display("FAIL mull_operands: got %h want %h", {md_a[0], md_b[0]}, {32'd7, 32'd6}); else n_pass++;
    @(posedge clk); #1;
    wait_result(w, r, gap);
    n_total++; if ({w, r} !== {2'b01, 32'd42}) $display("FAIL mull_result: got %b/%0d want 01/42", w, r); else n_pass++;
    n_total++; if (gap !== 1) $display("FAIL mull_rvalid_latency: got %0d want 1", gap); else n_pass++;
    #1;
    n_total++; if ({mult_en[0], rv_s, md_a[0]} !== {1'b0, 2'b00, 32'd7}) $display("FAIL mull_idle_hold: got %h want %h", {mult_en[0], rv_s, md_a[0]}, {1'b0, 2'b00, 32'd7}); else n_pass++;
  endtask

  task automatic test_tie();
    logic [1:0] g, w; logic [31:0] r; int gap;
    do_reset(); lat = 3;
    present(0, OP_DIV, 2'b00, 32'd100, 32'd7);
    present(1, OP_REM, 2'b00, 32'd100, 32'd7);
    wait_grant(g);
    n_total++; if (g !== 2'b01) $display("FAIL tie_first_grant: got %b want 01", g); else n_pass++;
    present(0, OP_MULL, 2'b00, 32'd9, 32'd9);
    wait_result(w, r, gap);
    n_total++; if ({w, r} !== {2'b01, 32'd14}) $display("FAIL tie_div_result: got %b/%0d want 01/14", w, r); else n_pass++;
    wait_grant(g);
    n_total++; if (g !== 2'b10) $display("FAIL tie_second_grant: got %b want 10", g); else n_pass++;
    present(1, OP_MULL, 2'b00, 32'd3, 32'd3);
    wait_result(w, r, gap);
    n_total++; if ({w, r} !== {2'b10, 32'd2}) $display("FAIL tie_rem_result: got %b/%0d want 10/2", w, r); else n_pass++;
    wait_grant(g);
    n_total++; if (g !== 2'b01) $display("FAIL tie_reverse_grant: got %b want 01", g); else n_pass++;
    vld[0] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({w, r} !== {2'b01, 32'd81}) $display("FAIL tie_mull0_result: got %b/%0d want 01/81", w, r); else n_pass++;
    wait_grant(g);
    vld[1] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({g, w, r} !== {2'b10, 2'b10, 32'd9}) $display("FAIL tie_mull1: got %b/%b/%0d want 10/10/9", g, w, r); else n_pass++;
  endtask

  task automatic test_div0();
    logic [1:0] g, w; logic [31:0] r; int gap;
    do_reset(); lat = 3;
    present(1, OP_DIV, 2'b00, 32'd100, 32'd0);
    wait_grant(g); vld[1] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({g, w, r} !== {2'b10, 2'b10, 32'hFFFF_FFFF}) $display("FAIL div_by_zero: got %b/%b/%h want 10/10/ffffffff", g, w, r); else n_pass++;
    present(1, OP_REM, 2'b00, 32'd100, 32'd0);
    wait_grant(g); vld[1] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({g, w, r} !== {2'b10, 2'b10, 32'd100}) $display("FAIL rem_by_zero: got %b/%b/%0d want 10/10/100", g, w, r); else n_pass++;
  endtask

  task automatic test_abort();
    logic [1:0] g, w; logic [31:0] r; int gap;
    bit rv_any, en_drop, done;
    do_reset();
    abort = 1'b1;
    present(0, OP_DIV, 2'b00, 32'd1000, 32'd3);
    #1;
    n_total++; if (rdy_s !== 2'b00) $display("FAIL abort_idle_ready: got %b want 00", rdy_s); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (busy[0] !== 1'b0) $display("FAIL abort_idle_busy: got %b want 0", busy[0]); else n_pass++;
    abort = 1'b0; lat = 6;
    wait_grant(g); vld[0] = 1'b0;
    n_total++; if (g !== 2'b01) $display("FAIL abort_div_grant: got %b want 01", g); else n_pass++;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    rv_any = 1'b0; en_drop = 1'b0; done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      if (rv_s != 2'b00) rv_any = 1'b1;
      if (!busy[0]) done = 1'b1;
      else if (!div_en[0] || mult_en[0] || md_a[0] != 32'd1000) en_drop = 1'b1;
      @(posedge clk); #1;
    end
    n_total++; if ({done, rv_any, en_drop} !== 3'b100) $display("FAIL abort_drain: got done/rv/drop %b want 100", {done, rv_any, en_drop}); else n_pass++;
    lat = 2;
    present(0, OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_grant(g); vld[0] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({g, w, r} !== {2'b01, 2'b01, 32'd0}) $display("FAIL abort_then_mulh: got %b/%b/%h want 01/01/0", g, w, r); else n_pass++;
  endtask

  task automatic test_abort_resp();
    logic [1:0] g;
    bit seen;
    do_reset(); lat = 3;
    present(0, OP_MULL, 2'b00, 32'd5, 32'd5);
    wait_grant(g); vld[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (md_valid[0]) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_total++; if (seen !== 1'b1) $display("FAIL abort_resp_done_seen: got %b want 1", seen); else n_pass++;
    @(posedge clk); #1; abort = 1'b1; #1;
    n_total++; if ({busy[0], rv_s} !== 3'b100) $display("FAIL abort_resp_suppress: got %b want 100", {busy[0], rv_s}); else n_pass++;
    @(posedge clk); #1; abort = 1'b0; #1;
    n_total++; if ({busy[0], rv_s} !== 3'b000) $display("FAIL abort_resp_idle: got %b want 000", {busy[0], rv_s}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, w; logic [31:0] r; int gap;
    do_reset(); lat = 8;
    present(0, OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_grant(g); vld[0] = 1'b0;
    @(posedge clk); #1;
    vld = 2'b11;
    #2; rst_ni = 1'b0; #1;
    n_total++; if ({busy, mult_en, div_en, rdy_s, rv_s} !== 10'd0) $display("FAIL reset_mid_ctrl: got %b want 0", {busy, mult_en, div_en, rdy_s, rv_s}); else n_pass++;
    n_total++; if ({md_a[0], md_b[0], md_opr[0], md_sgn[0], res_s[0]} !== 100'd0) $display("FAIL reset_mid_data: got %h want 0", {md_a[0], md_b[0], md_opr[0], md_sgn[0], res_s[0]}); else n_pass++;
    @(posedge clk); #1;
    rst_ni = 1'b1; vld = 2'b00; lat = 1;
    present(0, OP_MULL, 2'b00, 32'd3, 32'd5);
    wait_grant(g); vld[0] = 1'b0;
    wait_result(w, r, gap);
    n_total++; if ({g, w, r} !== {2'b01, 2'b01, 32'd15}) $display("FAIL reset_mid_mull: got %b/%b/%0d want 01/01/15", g, w, r); else n_pass++;
  endtask

  task automatic test_fixed_priority();
    int g0, g1, bad;
    do_reset(); lat = 2;
    present(0, OP_MULL, 2'b00, 32'd2, 32'd2);
    present(1, OP_MULL, 2'b00, 32'd3, 32'd3);
    g0 = 0; g1 = 0; bad = 0;
    // Accept-to-accept spacing is latency + 2 = 4 cycles.
    for (int k = 0; k < 40; k++) begin
      #1;
      if (f_rdy_s[0]) g0++;
      if (f_rdy_s[1]) g1++;
      if (f_rv_s[0] && f_res_s[0] != 32'd4) bad++;
      if (f_rv_s[1]) bad++;
      @(posedge clk); #1;
    end
    n_total++; if ({g0, g1, bad} !== {32'd10, 32'd0, 32'd0}) $display("FAIL fixed_req0_wins: got g0=%0d g1=%0d bad=%0d want 10/0/0", g0, g1, bad); else n_pass++;
    vld[0] = 1'b0; g0 = 0; g1 = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (f_rdy_s[0]) g0++;
      if (f_rdy_s[1]) g1++;
      @(posedge clk); #1;
    end
    n_total++; if (g0 != 0 || g1 < 1) $display("FAIL fixed_req1_alone: got g0=%0d g1=%0d want 0 and >=1", g0, g1); else n_pass++;
    vld = 2'b00;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Random traffic against a model holding pending requests and last winner.
  task automatic test_random();
    logic [1:0] pend, g, w, exp_g;
    logic [31:0] r, exp_r;
    int last, exp_w, win, gap;
    do_reset();
    last = 1; pend = 2'b00;
    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(1, 0) == 1)) begin
          present(n, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), $urandom,
                  ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom);
          pend[n] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        present(0, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), $urandom, $urandom);
        pend[0] = 1'b1;
      end
      lat = $urandom_range(5, 1);
      exp_w = (pend == 2'b11) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
      exp_g = (exp_w == 1) ? 2'b10 : 2'b01;
      last = exp_w;
      wait_grant(g);
      n_total++; if (g !== exp_g) $display("FAIL rand_grant it%0d: got %b want %b", it, g, exp_g); else n_pass++;
      if (g == 2'b00) break;
      win = g[1] ? 1 : 0;
      vld[win] = 1'b0; pend[win] = 1'b0;
      exp_r = ref_md(opr[win], sgn[win], opa[win], opb[win]);
      wait_result(w, r, gap);
      n_total++; if ({w, r} !== {g, exp_r}) $display("FAIL rand_result it%0d: got %b/%h want %b/%h", it, w, r, g, exp_r); else n_pass++;
    end
    vld = 2'b00;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_ni = 1'b0; abort = 1'b0; vld = 2'b00; lat = 1;
    for (int i = 0; i < 2; i++) begin
      opr[i] = 2'd0; sgn[i] = 2'd0; opa[i] = 32'd0; opb[i] = 32'd0;
    end
    test_reset();
    test_mull();
    test_tie();
    test_div0();
    test_abort();
    test_abort_resp();
    test_reset_mid();
    test_fixed_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
